// File: rtl/code2421_monitor.sv
// Watches a 2421 (Aiken) up-counter digit stream: decodes it, checks the count sequence,
// flags illegal codes and keeps a saturating error tally.
module code2421_monitor #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           code_in,
  input  logic                 clear,
  output logic [3:0]           digit_bin,
  output logic                 valid,
  output logic                 carry,
  output logic                 seq_err,
  output logic                 inv_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] prev;
  logic       legal;
  logic [3:0] dec;
  logic [3:0] prev_inc;
  logic       carry_ev;
  logic       seq_ev;
  logic       inv_ev;

  always_comb begin
    legal = 1'b1;
    dec   = 4'd0;
    case (code_in)
      4'b0000: dec = 4'd0;
      4'b0001: dec = 4'd1;
      4'b0010: dec = 4'd2;
      4'b0011: dec = 4'd3;
      4'b0100: dec = 4'd4;
      4'b1011: dec = 4'd5;
      4'b1100: dec = 4'd6;
      4'b1101: dec = 4'd7;
      4'b1110: dec = 4'd8;
      4'b1111: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  assign prev_inc = (prev == 4'd9) ? 4'd0 : prev + 4'd1;

  // Event decode only matters in TRACK; the three events are exclusive by construction.
  always_comb begin
    carry_ev = 1'b0;
    seq_ev   = 1'b0;
    inv_ev   = 1'b0;
    if (state == TRACK) begin
      if (!legal)                carry_ev = 1'b0;
      else if (dec == prev_inc)  carry_ev = (prev == 4'd9);
      else if (dec != prev)      seq_ev   = 1'b1;
      inv_ev = !legal;
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      prev      <= 4'd0;
      digit_bin <= 4'd0;
      valid     <= 1'b0;
      carry     <= 1'b0;
      seq_err   <= 1'b0;
      inv_err   <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
    end else begin
      carry   <= carry_ev;
      seq_err <= seq_ev;
      inv_err <= inv_ev;
      valid   <= legal;
      if (legal) digit_bin <= dec;

      case (state)
        SYNC: begin
          if (legal) begin
            prev   <= dec;
            state  <= TRACK;
            locked <= 1'b1;
          end
        end
        TRACK: begin
          if (!legal) begin
            state  <= FAULT;
            locked <= 1'b0;
          end else begin
            prev <= dec;
          end
        end
        FAULT: begin
          // A legal code only re-arms SYNC; a second one is needed to capture prev.
          if (legal) state <= SYNC;
        end
        default: begin
          state  <= SYNC;
          locked <= 1'b0;
        end
      endcase

      if (clear)
        err_count <= '0;
      else if ((seq_ev || inv_ev) && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_code2421_monitor.sv
// Bench for code2421_monitor: directed scenarios plus a randomized digit stream,
// all checked against a digit-level reference model of the monitor.
module tb_code2421_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] code_in;
  logic       clear;

  logic [3:0] digit_bin, digit_bin2;
  logic       valid, carry, seq_err, inv_err, locked;
  logic       valid2, carry2, seq_err2, inv_err2, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [1:0] state_dbg, state_dbg2;

  code2421_monitor #(.ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .clear(clear),
    .digit_bin(digit_bin), .valid(valid), .carry(carry), .seq_err(seq_err),
    .inv_err(inv_err), .err_count(err_count), .locked(locked), .state_dbg(state_dbg)
  );

  code2421_monitor #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .code_in(code_in), .clear(clear),
    .digit_bin(digit_bin2), .valid(valid2), .carry(carry2), .seq_err(seq_err2),
    .inv_err(inv_err2), .err_count(err_count2), .locked(locked2), .state_dbg(state_dbg2)
  );

  // Observation vector: digit, valid, carry, seq, inv, locked, state, cnt8, cnt2.
  logic [20:0] obs;
  logic [10:0] obs2;
  assign obs  = {digit_bin, valid, carry, seq_err, inv_err, locked, state_dbg, err_count, err_count2};
  assign obs2 = {digit_bin2, valid2, carry2, seq_err2, inv_err2, locked2, state_dbg2};

  logic [20:0] exp_q[$];
  logic [20:0] exp;
  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [3:0] enc [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  int m_mode;   // 0 = hunting for a first digit, 1 = following the count, 2 = after a bad code
  int m_prev, m_digit, m_cnt8, m_cnt2;
  bit m_valid, e_carry, e_seq, e_inv;

  function automatic int decode(input logic [3:0] c);
    for (int i = 0; i < 10; i++) if (enc[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_digit = 0; m_cnt8 = 0; m_cnt2 = 0;
    m_valid = 0; e_carry = 0; e_seq = 0; e_inv = 0;
  endtask

  task automatic model_update(input logic [3:0] c, input logic clr);
    int d;
    d = decode(c);
    e_carry = 0; e_seq = 0; e_inv = 0;
    m_valid = (d >= 0);
    if (d >= 0) m_digit = d;
    if (m_mode == 0) begin
      if (d >= 0) begin m_prev = d; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (d < 0) begin
        e_inv = 1; m_mode = 2;
      end else if (d == (m_prev + 1) % 10) begin
        e_carry = (d == 0); m_prev = d;
      end else if (d != m_prev) begin
        e_seq = 1; m_prev = d;
      end
    end else begin
      if (d >= 0) m_mode = 0;
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (e_seq || e_inv) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
  endtask

  function automatic logic [20:0] model_vec();
    return {4'(m_digit), m_valid, e_carry, e_seq, e_inv, (m_mode == 1), 2'(m_mode), 8'(m_cnt8), 2'(m_cnt2)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] c, input logic clr);
    code_in = c;
    clear   = clr;
    @(posedge clk);
    model_update(c, clr);
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    code_in = 4'h0;
    clear = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; code_in = 4'h7; clear = 1'b0;
    model_reset();
    #3;
    total++;
    if (obs !== 21'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 21'd0); end
    total++;
    if (obs2 !== 11'd0) begin bad++; $display("FAIL reset_outputs_w2 got=%h exp=%h", obs2, 11'd0); end
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_count();
    int ncarry = 0;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      step(enc[i % 10], 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL count[%0d] got=%h exp=%h", i, obs, exp); end
      if (carry) ncarry++;
      if (i == 0) begin
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL count_lock got=%b exp=1", locked); end
      end
    end
    total++;
    if (ncarry != 1) begin bad++; $display("FAIL count_carries got=%0d exp=1", ncarry); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL count_errs got=%0d exp=0", err_count); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL hold[%0d] got=%h exp=%h", i, obs, exp); end
    end
    total++;
    if (digit_bin !== 4'd3) begin bad++; $display("FAIL hold_digit got=%0d exp=3", digit_bin); end
    step(4'b0100, 1'b0);
    exp = exp_q.pop_front();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL hold_step got=%h exp=%h", obs, exp); end
    total++;
    if ({digit_bin, seq_err, inv_err, err_count} !== {4'd4, 1'b0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL hold_next got=%0d/%b/%b/%0d exp=4/0/0/0", digit_bin, seq_err, inv_err, err_count);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step(4'b0010, 1'b0);
    exp = exp_q.pop_front();
    step(4'b1100, 1'b0);
    exp = exp_q.pop_front();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL jump got=%h exp=%h", obs, exp); end
    total++;
    if ({seq_err, err_count} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL jump_seq got=%b/%0d exp=1/1", seq_err, err_count);
    end
    step(4'b1101, 1'b0);
    exp = exp_q.pop_front();
    total++;
    if ({seq_err, inv_err, err_count, digit_bin} !== {1'b0, 1'b0, 8'd1, 4'd7}) begin
      bad++; $display("FAIL jump_after got=%b/%b/%0d/%0d exp=0/0/1/7", seq_err, inv_err, err_count, digit_bin);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] codes [5] = '{4'b0010, 4'b0101, 4'b0110, 4'b0001, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(codes[i], 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL invalid[%0d] got=%h exp=%h", i, obs, exp); end
      if (i == 1) begin
        total++;
        if ({inv_err, valid, locked, digit_bin} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
          bad++; $display("FAIL invalid_hit got=%b/%b/%b/%0d exp=1/0/0/2", inv_err, valid, locked, digit_bin);
        end
      end
      if (i == 3) begin
        total++;
        if ({state_dbg, locked, inv_err} !== {2'd0, 1'b0, 1'b0}) begin
          bad++; $display("FAIL invalid_sync got=%0d/%b/%b exp=0/0/0", state_dbg, locked, inv_err);
        end
      end
    end
    total++;
    if ({locked, err_count} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL invalid_relock got=%b/%0d exp=1/1", locked, err_count);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] codes [6] = '{4'h0, 4'hB, 4'h2, 4'hE, 4'h1, 4'hC};
    do_reset();
    step(4'h0, 1'b0);
    exp = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      step(codes[i], 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sat[%0d] got=%h exp=%h", i, obs, exp); end
    end
    total++;
    if ({err_count2, err_count} !== {2'd3, 8'd5}) begin
      bad++; $display("FAIL sat_level got=%0d/%0d exp=3/5", err_count2, err_count);
    end
    step(4'h3, 1'b1);
    exp = exp_q.pop_front();
    total++;
    if ({seq_err2, err_count2, err_count} !== {1'b1, 2'd0, 8'd0}) begin
      bad++; $display("FAIL sat_clear got=%b/%0d/%0d exp=1/0/0", seq_err2, err_count2, err_count);
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i <= 7; i++) begin
      step(enc[i], 1'b0);
      exp = exp_q.pop_front();
    end
    total++;
    if ({digit_bin, locked} !== {4'd7, 1'b1}) begin
      bad++; $display("FAIL areset_pre got=%0d/%b exp=7/1", digit_bin, locked);
    end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 21'd0) begin bad++; $display("FAIL areset_now got=%h exp=%h", obs, 21'd0); end
    #2;
    reset = 1'b1;
    step(4'b1000, 1'b0);
    exp = exp_q.pop_front();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL areset_after got=%h exp=%h", obs, exp); end
    total++;
    if ({state_dbg, locked, inv_err, valid} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL areset_sync got=%0d/%b/%b/%b exp=0/0/0/0", state_dbg, locked, inv_err, valid);
    end
  endtask

  task automatic test_random();
    int d = 0;
    int r;
    logic [3:0] c;
    logic clr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 60)      begin d = (d + 1) % 10; c = enc[d]; end
      else if (r < 72) c = enc[d];
      else if (r < 88) begin d = $urandom_range(9); c = enc[d]; end
      else             c = 4'(5 + $urandom_range(5));
      clr = ($urandom_range(99) < 5);
      step(c, clr);
      exp = exp_q.pop_front();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random[%0d] code=%h got=%h exp=%h", i, c, obs, exp); end
      total++;
      if (obs2 !== exp[20:10]) begin bad++; $display("FAIL random_w2[%0d] got=%h exp=%h", i, obs2, exp[20:10]); end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_jump();
    test_invalid();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code2421_monitor.md
CODE2421_MONITOR -- requirements
Module: code2421_monitor

Interface
REQ-001 Parameter: ERR_CNT_W, 8, width of the saturating error counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: code_in  input  4  2421 (Aiken) digit from the upstream up-counter's upcount output.
REQ-005 Port: clear  input  1  synchronous clear of err_count, active-high.
REQ-006 Port: digit_bin  output  4  registered binary value (0-9) of the last valid code_in.
REQ-007 Port: valid  output  1  registered; 1 when the last sampled code_in was a legal 2421 code.
REQ-008 Port: carry  output  1  one-cycle pulse when a 9->0 rollover is observed.
REQ-009 Port: seq_err  output  1  one-cycle pulse when a legal code changes to a value other than previous+1 (mod 10).
REQ-010 Port: inv_err  output  1  one-cycle pulse when an illegal code is sampled in TRACK.
REQ-011 Port: err_count  output  ERR_CNT_W  saturating count of seq_err plus inv_err events.
REQ-012 Port: locked  output  1  registered; 1 while the FSM is in TRACK.

Function
REQ-013 The block SHALL decode 2421 as: 0000=0, 0001=1, 0010=2, 0011=3, 0100=4, 1011=5, 1100=6, 1101=7, 1110=8, 1111=9.
REQ-014 The block SHALL treat codes 0101, 0110, 0111, 1000, 1001 and 1010 as illegal.
REQ-015 The block SHALL sample code_in on every rising clk edge; it SHALL NOT use a separate enable.
REQ-016 All outputs SHALL be registered, with one-cycle latency from the sampling edge.
REQ-017 On a legal sample, digit_bin SHALL take the decoded value and valid SHALL be 1.
REQ-018 On an illegal sample, digit_bin SHALL hold its previous value and valid SHALL be 0.
REQ-019 The FSM SHALL have three states: SYNC, TRACK and FAULT.
REQ-020 SYNC: a legal sample SHALL capture prev := decoded value and go to TRACK; an illegal sample SHALL stay in SYNC with no error pulse.
REQ-021 TRACK: a legal sample equal to prev SHALL cause no pulse and stay in TRACK.
REQ-022 TRACK: a legal sample equal to (prev+1) mod 10 SHALL update prev and stay in TRACK; if prev=9 and the sample=0, carry SHALL pulse.
REQ-023 TRACK: any other legal sample SHALL pulse seq_err, resynchronise prev to the new value, and stay in TRACK.
REQ-024 TRACK: an illegal sample SHALL pulse inv_err and go to FAULT; prev SHALL be unchanged.
REQ-025 FAULT: an illegal sample SHALL stay in FAULT with no further pulse; a legal sample SHALL go to SYNC without capturing prev.
REQ-026 Recovery from FAULT SHALL therefore require two consecutive legal samples before re-entering TRACK.
REQ-027 carry, seq_err and inv_err SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per event.
REQ-028 err_count SHALL increment by 1 on each seq_err or inv_err event and SHALL saturate at 2^ERR_CNT_W-1 without wrapping.
REQ-029 clear SHALL set err_count to 0 on the next edge, taking priority over a coincident error increment.
REQ-030 clear SHALL NOT affect the FSM, prev or any other output.
REQ-031 locked SHALL be 1 exactly in the cycles after the FSM has entered TRACK and before it leaves it.

Reset
REQ-032 While reset=0, the block SHALL asynchronously force: state=SYNC, prev=0, digit_bin=0, valid=0, carry=0, seq_err=0, inv_err=0, err_count=0, locked=0.
REQ-033 Asserting reset mid-operation SHALL discard all tracking history; after release, the block SHALL behave as from power-up.
REQ-034 After reset release, the first edge SHALL sample normally, with no extra wait cycle.

Verification
REQ-035 The bench SHALL apply reset, then count 0..9..0 one code per cycle -> locked=1 from the cycle after the first sample, digit_bin follows with 1-cycle lag, and carry pulses exactly once (on 1111->0000), with err_count=0.
REQ-036 The bench SHALL drive code_in holding 0011 for 5 cycles, then 0100 -> no error pulses; digit_bin goes 3 then 4.
REQ-037 The bench SHALL jump from 0010 to 1100 in TRACK -> seq_err pulses 1 cycle, err_count=1, and a following 1101 produces no error.
REQ-038 The bench SHALL drive 0101 in TRACK -> inv_err pulses once, valid=0, locked=0, digit_bin holds; then 0110, 0001, 0001 -> no further pulse, SYNC after the first 0001, locked=1 after the second 0001.
REQ-039 The bench SHALL force ERR_CNT_W=2 and inject 5 seq errors -> err_count saturates at 3; asserting clear together with a 6th error -> err_count=0.
REQ-040 The bench SHALL assert reset asynchronously (between edges) while in TRACK at digit 7 -> all outputs are 0 immediately; after release, code 1000 is ignored and the FSM stays in SYNC.
